// File: rtl/tdm_mux.sv
// Registered N-channel multiplexer: manual select or round-robin auto scan with
// per-channel dwell, channel tag, frame pulse and out-of-range flag.
module tdm_mux #(
  parameter int CH    = 8,
  parameter int W     = 8,
  parameter int DWELL = 1,
  localparam int SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   din,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   ch,
  output logic              valid,
  output logic              frame,
  output logic              err
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CH - 1);
  localparam logic [DW-1:0]   LAST_DWL = DW'(DWELL - 1);

  logic [SELW-1:0] scan_ch;
  logic [DW-1:0]   dwell_cnt;
  logic [W-1:0]    man_y;
  logic [W-1:0]    scan_y;
  logic            man_hit;

  // An unmatched manual select yields zero data and raises err.
  always_comb begin
    man_y   = '0;
    man_hit = 1'b0;
    scan_y  = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SELW'(k)) begin
        man_y   = din[k*W +: W];
        man_hit = 1'b1;
      end
      if (scan_ch == SELW'(k)) scan_y = din[k*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      ch        <= '0;
      valid     <= 1'b0;
      frame     <= 1'b0;
      err       <= 1'b0;
      scan_ch   <= '0;
      dwell_cnt <= '0;
    end else if (!en) begin
      valid <= 1'b0;
      frame <= 1'b0;
      err   <= 1'b0;
    end else if (!mode) begin
      y         <= man_y;
      ch        <= sel;
      valid     <= 1'b1;
      err       <= !man_hit;
      frame     <= 1'b0;
      scan_ch   <= '0;
      dwell_cnt <= '0;
    end else begin
      y     <= scan_y;
      ch    <= scan_ch;
      valid <= 1'b1;
      err   <= 1'b0;
      frame <= (scan_ch == '0) && (dwell_cnt == '0);
      if (dwell_cnt == LAST_DWL) begin
        dwell_cnt <= '0;
        scan_ch   <= (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Scoreboard bench for tdm_mux: two instances (CH=8/DWELL=1 and CH=6/DWELL=3).
module tb_tdm_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] din8;
  logic [47:0] din6;
  logic en8 = 1'b0, mode8 = 1'b0, en6 = 1'b0, mode6 = 1'b0;
  logic [2:0] sel8 = '0, sel6 = '0;
  logic [7:0] y8, y6;
  logic [2:0] ch8, ch6;
  logic v8, f8, e8, v6, f6, e6;

  tdm_mux #(.CH(8), .W(8), .DWELL(1)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .en(en8), .mode(mode8), .sel(sel8),
    .y(y8), .ch(ch8), .valid(v8), .frame(f8), .err(e8));

  tdm_mux #(.CH(6), .W(8), .DWELL(3)) dut6 (
    .clk(clk), .rst(rst), .din(din6), .en(en6), .mode(mode6), .sel(sel6),
    .y(y6), .ch(ch6), .valid(v6), .frame(f6), .err(e6));

  typedef struct {
    int         tgt;
    bit         which;
    logic [7:0] y;
    logic [2:0] ch;
    logic       v, f, e;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: pops every expectation whose edge has passed and compares.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tgt <= edge_cnt) begin
        automatic exp_t x = q.pop_front();
        automatic logic [7:0] ay = x.which ? y6 : y8;
        automatic logic [2:0] ac = x.which ? ch6 : ch8;
        automatic logic av = x.which ? v6 : v8;
        automatic logic af = x.which ? f6 : f8;
        automatic logic ae = x.which ? e6 : e8;
        checks++;
        if (ay !== x.y || ac !== x.ch || av !== x.v || af !== x.f || ae !== x.e) begin
          errors++;
          $display("FAIL %s edge %0d: got y=%h ch=%0d v=%b f=%b e=%b, want y=%h ch=%0d v=%b f=%b e=%b",
                   x.nm, x.tgt, ay, ac, av, af, ae, x.y, x.ch, x.v, x.f, x.e);
        end
      end
    end
  end

  // Called just after a rising edge; sets inputs for and expectation of the next edge.
  task automatic drv(input bit w, input logic e, input logic m, input logic [2:0] s,
                     input logic [7:0] ey, input logic [2:0] ec,
                     input logic ev, input logic ef, input logic ee, input string nm);
    exp_t x;
    if (w) begin en6 = e; mode6 = m; sel6 = s; end
    else   begin en8 = e; mode8 = m; sel8 = s; end
    x.tgt = edge_cnt + 1; x.which = w; x.y = ey; x.ch = ec;
    x.v = ev; x.f = ef; x.e = ee; x.nm = nm;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic set_din();
    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = 8'(k * 8'h11);
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(k * 8'h11);
  endtask

  initial begin
    int c;
    din8 = '0;
    din6 = '0;
    @(posedge clk); #1;

    // Reset held over three edges while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      din8 = {8{8'hA5 ^ 8'(i)}};
      drv(0, 1, 0, 3'(i + 3), 8'h00, 3'd0, 0, 0, 0, "reset_hold");
    end
    set_din();
    rst = 1'b0;

    // Manual select.
    drv(0, 1, 0, 3'd0, 8'h00, 3'd0, 1, 0, 0, "manual_sel0");
    drv(0, 1, 0, 3'd3, 8'h33, 3'd3, 1, 0, 0, "manual_sel3");
    drv(0, 1, 0, 3'd7, 8'h77, 3'd7, 1, 0, 0, "manual_sel7");

    // Auto scan, DWELL=1, with wrap.
    for (int i = 0; i < 10; i++) begin
      c = i % 8;
      drv(0, 1, 1, 3'd0, 8'(c * 8'h11), 3'(c), 1, (c == 0), 0, "auto8");
    end
    drv(0, 0, 1, 3'd0, 8'h11, 3'd1, 0, 0, 0, "auto8_pause_hold");

    // Asynchronous reset between edges.
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (y8 !== 8'h00 || ch8 !== 3'd0 || v8 !== 1'b0 || f8 !== 1'b0 || e8 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got y=%h ch=%0d v=%b f=%b e=%b, want all zero", y8, ch8, v8, f8, e8);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // First auto edge after reset, then switch to manual at ch=4 and back.
    for (int i = 0; i < 5; i++)
      drv(0, 1, 1, 3'd0, 8'(i * 8'h11), 3'(i), 1, (i == 0), 0, "auto8_after_reset");
    drv(0, 1, 0, 3'd2, 8'h22, 3'd2, 1, 0, 0, "switch_to_manual");
    drv(0, 1, 1, 3'd2, 8'h00, 3'd0, 1, 1, 0, "switch_to_auto");
    drv(0, 1, 1, 3'd2, 8'h11, 3'd1, 1, 0, 0, "switch_to_auto_next");
    en8 = 1'b0;

    // CH=6, DWELL=3; pause for two cycles on the first cycle of ch=2.
    for (int i = 0; i < 7; i++) begin
      c = (i / 3) % 6;
      drv(1, 1, 1, 3'd0, 8'(c * 8'h11), 3'(c), 1, (i % 18 == 0), 0, "dwell6");
    end
    drv(1, 0, 1, 3'd0, 8'h22, 3'd2, 0, 0, 0, "dwell6_pause");
    drv(1, 0, 1, 3'd0, 8'h22, 3'd2, 0, 0, 0, "dwell6_pause");
    for (int i = 7; i < 20; i++) begin
      c = (i / 3) % 6;
      drv(1, 1, 1, 3'd0, 8'(c * 8'h11), 3'(c), 1, (i % 18 == 0), 0, "dwell6_resume");
    end

    // Out-of-range manual select on CH=6.
    drv(1, 1, 0, 3'd6, 8'h00, 3'd6, 1, 0, 1, "oor_sel6");
    drv(1, 1, 0, 3'd7, 8'h00, 3'd7, 1, 0, 1, "oor_sel7");
    drv(1, 1, 0, 3'd5, 8'h55, 3'd5, 1, 0, 0, "inrange_sel5");
    en6 = 1'b0;

    @(negedge clk); #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux.md
# tdm_mux

Parametrised, registered N-channel multiplexer with two select modes. In manual mode an external select picks the channel. In auto mode an internal sequencer scans all channels round-robin, dwelling a programmable number of cycles on each. It supersedes the fixed 2:1/4:1/8:1 combinational muxes wherever the selected data must be registered, tagged with its channel, and framed for a downstream serial or TDM consumer.

## Interface
- CH, default 8: number of input channels; ≥2; need not be a power of two.
- W, default 8: data width per channel; ≥1.
- DWELL, default 1: cycles spent on each channel in auto mode; ≥1.
- SELW, derived, $clog2(CH): select/channel-index width; not overridable.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- din  in  CH*W  packed channel data; channel k occupies bits [k*W +: W].
- en  in  1  advance enable; when 0 the block pauses.
- mode  in  1  0 = manual select, 1 = auto scan.
- sel  in  SELW  manual channel select; ignored when mode=1.
- y  out  W  registered selected data.
- ch  out  SELW  index of the channel presented on y.
- valid  out  1  y/ch updated on the previous edge.
- frame  out  1  single-cycle pulse marking channel 0 at the start of an auto scan.
- err  out  1  manual sel ≥ CH on the previous edge.

## Operation
- Internal state:
  - scan_ch[SELW], the next channel in auto mode.
  - dwell_cnt, range 0..DWELL-1, width $clog2(DWELL) with a minimum of 1.
- Edge with en=1, mode=0 (manual):
  - y ← din[sel], or 0 if sel ≥ CH.
  - ch ← sel, valid ← 1, err ← (sel ≥ CH), frame ← 0.
  - scan_ch ← 0 and dwell_cnt ← 0, so auto mode always starts at channel 0.
- Edge with en=1, mode=1 (auto):
  - y ← din[scan_ch], ch ← scan_ch, valid ← 1, err ← 0.
  - frame ← (scan_ch==0 && dwell_cnt==0).
  - If dwell_cnt==DWELL-1: dwell_cnt ← 0 and scan_ch ← (scan_ch==CH-1) ? 0 : scan_ch+1.
  - Otherwise dwell_cnt ← dwell_cnt+1.
- Edge with en=0:
  - y and ch hold.
  - valid ← 0, frame ← 0, err ← 0.
  - scan_ch and dwell_cnt hold, so the scan resumes exactly where it paused.
- Mode change:
  - Manual→auto: the first auto edge outputs channel 0 with frame=1.
  - Auto→manual: takes effect on the next edge; the scan position is discarded.
- Wrap: scan_ch never takes a value ≥ CH; CH-1 wraps to 0.
- din is sampled only at the edge. Changes to din between edges have no effect on y until the next enabled edge.

## Timing
- Latency is 1 cycle: inputs sampled at edge n appear on y/ch/valid/err/frame after edge n.
- Outputs are purely registered; no combinational path from any input to any output.
- Reset values: y=0, ch=0, valid=0, frame=0, err=0, scan_ch=0, dwell_cnt=0.
- rst asserted mid-operation clears all state immediately, without waiting for clk.
- First enabled edge after rst deasserts, with mode=1, produces ch=0 and frame=1.
- Auto frame period is CH*DWELL enabled cycles; frame is high for exactly one of them.
- Each channel is presented for DWELL consecutive enabled cycles.

## Test plan
- Reset: hold rst=1 for 3 edges, with din and sel toggling -> y=0, ch=0, valid=0, frame=0, err=0 throughout. Assert rst between edges -> all outputs 0 before the next edge.
- Manual select: CH=8, W=8, din={8'h77,8'h66,…,8'h00}, en=1, mode=0, sel=0,3,7 on successive edges -> y=00,33,77 one cycle later; ch matches sel; valid=1; err=0.
- Auto scan, DWELL=1: same din, mode=1 for 10 edges -> y=00,11,…,77,00,11; ch=0..7,0,1; frame=1 only on the two ch=0 cycles.
- Dwell and pause: CH=6, DWELL=3, mode=1 -> each ch held 3 cycles, frame every 18 cycles. Drop en for 2 cycles mid-dwell on ch=2 -> valid=0 and y/ch hold; after en returns, the remaining dwell count for ch=2 completes.
- Out-of-range select: CH=6, mode=0, sel=6 then sel=7 -> y=0, err=1, valid=1. Then sel=5 -> err=0, y=din[5].
- Mode switch: in auto mode at ch=4, set mode=0 with sel=2 -> next output ch=2. Return to mode=1 -> next output ch=0 with frame=1.
